fir_coef_sequencer: RTL and testbench
=====================================

# fir_coef_sequencer

Single-clock controller that programs the FIR filter's coefficient shift chain from a synchronous coefficient ROM holding up to eight filter banks, selected by the switch inputs. It also generates the 44.1 kHz sample-enable that paces the filter datapath, and holds that enable off while coefficients are in flight. It sits between the switch/bank-select logic, the coefficient ROM and the FIR instance, replacing the free-running divider and the tied-off coefficient port.

## Interface
Parameters:
- NUM_TAPS, 32 — coefficients per bank; power of two, ≥ 4.
- COEF_W, 16 — coefficient width.
- BANK_W, 3 — bank-select width.
- SAMPLE_DIV, 566 — system clocks per sample tick.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- bank_sel  in  BANK_W  requested coefficient bank (switches).
- load_req  in  1  single-cycle request to reload the current bank.
- rom_addr  out  BANK_W+log2(NUM_TAPS)  {bank, tap} ROM address.
- rom_en  out  1  ROM read enable.
- rom_data  in  COEF_W  ROM output, valid one cycle after rom_en.
- coef_out  out  COEF_W  coefficient to the FIR shift chain.
- coef_valid  out  1  coefficient shift strobe; one FIR shift per asserted cycle.
- sample_tick  out  1  free-running one-cycle pulse every SAMPLE_DIV clocks.
- sample_en  out  1  sample_tick gated off while busy.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes.

## Operation
- States: IDLE, LOAD, DRAIN, FINISH.
- IDLE: leave when pending is set or load_req = 1. On leaving, latch bank_sel into bank_q, set tap_idx = NUM_TAPS-1, clear pending, and go to LOAD.
- LOAD:
  - rom_en = 1, rom_addr = {bank_q, tap_idx}.
  - Decrement tap_idx each cycle.
  - After issuing tap 0, go to DRAIN.
  - Taps are issued in descending order (NUM_TAPS-1 first), so tap 0 is the last one shifted in.
- DRAIN: two cycles, rom_en = 0, for the ROM latency and the output register. Then go to FINISH.
- FINISH: one cycle. done = 1, then go to IDLE.
- Output pipeline: coef_out ← rom_data and coef_valid ← rom_en delayed by two registers, giving exactly NUM_TAPS strobes per load.
- pending flag:
  - Set out of reset (power-on load).
  - Set whenever bank_sel differs from bank_q for 2 consecutive cycles (simple debounce) while not in IDLE-entry.
  - load_req while busy is ignored and does not set pending.
- Bank change mid-load: the current load completes with the old bank, then the block reloads immediately from IDLE.
- Sample timer:
  - Counter runs 0..SAMPLE_DIV-1 regardless of state.
  - sample_tick = 1 when count = SAMPLE_DIV-1; the counter then wraps to 0.
- sample_en = sample_tick & ~busy.
- busy = 1 in LOAD, DRAIN and FINISH.

## Timing
- Reset values:
  - All outputs 0, rom_addr = 0, state IDLE, timer count 0, bank_q = 0, pending = 1.
  - The first load therefore begins on the first clock after reset deassertion.
- Load latency, with cycle 0 as the first LOAD cycle:
  - rom_en is high on cycles 0..NUM_TAPS-1.
  - coef_valid is high on cycles 2..NUM_TAPS+1.
  - done pulses on cycle NUM_TAPS+2.
  - busy is high on cycles 0..NUM_TAPS+2.
  - Next IDLE is cycle NUM_TAPS+3.
- load_req in IDLE enters LOAD on the next cycle. Simultaneous load_req and pending produce a single load.
- A sample_tick coinciding with busy is dropped, not deferred.
- Reset asserted mid-load:
  - All outputs clear immediately.
  - Partial FIR contents are accepted, because the power-on load rewrites them.
- tap_idx wraps from 0 only on the LOAD→DRAIN transition and is never used after wrapping.

## Structure
- A shared package holds the state encoding (IDLE/LOAD/DRAIN/FINISH), the TAP_W = log2(NUM_TAPS) helper, and the default SAMPLE_DIV constant, shared with the other audio blocks.
- One sub-module, sample_timer: the modulo-SAMPLE_DIV counter with its tick output. It is reusable wherever a 44.1 kHz enable is needed.
- The FSM, debounce, pending logic and the 2-stage output pipeline stay in the top module.

## Test plan
- Power-on: release reset with bank_sel = 3 and NUM_TAPS = 32.
  - rom_addr runs 0x7F down to 0x60.
  - Exactly 32 coef_valid strobes, each equal to the ROM model's data.
  - done on cycle 34.
- load_req pulse in IDLE with bank_sel = 5:
  - Reload addresses 0xBF..0xA0.
  - A second load_req at cycle 10 of the load produces no extra load.
- bank_sel changes 5→2 at cycle 8 of a load:
  - The bank-5 load completes.
  - The bank-2 load starts the cycle after IDLE is re-entered.
- Timer:
  - sample_tick period is exactly 566 cycles with no load running.
  - A tick falling inside busy gives sample_en = 0; the next tick gives sample_en = 1.
- Reset asserted at cycle 15 of a load:
  - coef_valid, busy, rom_en and done go to 0 immediately.
  - After release, a full power-on load of the current bank_sel follows.
- NUM_TAPS = 4 and SAMPLE_DIV = 3 build: 4 strobes, done on cycle 6, tick every 3 cycles.

Source files
------------

// File: rtl/fir_coef_sequencer_pkg.sv
// Shared definitions for the FIR coefficient sequencer and the other audio blocks:
// sequencer state encoding, tap-index width helper and the default 44.1 kHz divider.
package fir_coef_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } seq_state_e;

  localparam int SAMPLE_DIV_DEFAULT = 566;

  function automatic int tap_w(input int num_taps);
    return $clog2(num_taps);
  endfunction

endpackage

// File: rtl/fir_coef_sequencer_sample_timer.sv
// Modulo-DIV free-running counter; o_tick is high for the one cycle the count
// sits at DIV-1, after which the count wraps to 0.
module fir_coef_sequencer_sample_timer
  import fir_coef_sequencer_pkg::*;
#(
  parameter int DIV = SAMPLE_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_count;
  logic             w_at_end;

  assign w_at_end = (r_count == CNT_W'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_at_end) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tick = w_at_end;

endmodule

// File: rtl/fir_coef_sequencer.sv
// Streams one coefficient bank from the synchronous ROM into the FIR shift chain
// (highest tap first) and gates the 44.1 kHz sample enable while a load is in flight.
module fir_coef_sequencer
  import fir_coef_sequencer_pkg::*;
#(
  parameter int NUM_TAPS   = 32,
  parameter int COEF_W     = 16,
  parameter int BANK_W     = 3,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BANK_W-1:0]                 bank_sel,
  input  logic                              load_req,
  output logic [BANK_W+tap_w(NUM_TAPS)-1:0] rom_addr,
  output logic                              rom_en,
  input  logic [COEF_W-1:0]                 rom_data,
  output logic [COEF_W-1:0]                 coef_out,
  output logic                              coef_valid,
  output logic                              sample_tick,
  output logic                              sample_en,
  output logic                              busy,
  output logic                              done
);

  localparam int TAP_W = tap_w(NUM_TAPS);

  seq_state_e        r_state;
  logic [BANK_W-1:0] r_bank_q;
  logic [TAP_W-1:0]  r_tap_idx;
  logic              r_drain_cnt;
  logic              r_pending;
  logic              r_diff_q;
  logic              r_en_d1;
  logic              r_valid;
  logic [COEF_W-1:0] r_coef;
  logic              w_start;
  logic              w_diff;
  logic              w_tick;

  assign w_diff  = (bank_sel != r_bank_q);
  assign w_start = (r_state == IDLE) && (r_pending || load_req);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_bank_q    <= '0;
      r_tap_idx   <= '0;
      r_drain_cnt <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_bank_q  <= bank_sel;
            r_tap_idx <= TAP_W'(NUM_TAPS - 1);
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          // tap_idx wraps here after tap 0 but is not looked at again until the next IDLE exit
          r_tap_idx <= r_tap_idx - TAP_W'(1);
          if (r_tap_idx == '0) begin
            r_drain_cnt <= 1'b0;
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          r_drain_cnt <= 1'b1;
          if (r_drain_cnt) r_state <= FINISH;
        end
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A bank change must persist for two cycles before it schedules a reload;
  // the pending flag starts set so the first load happens straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b1;
      r_diff_q  <= 1'b0;
    end else begin
      r_diff_q <= w_diff;
      if (w_start) begin
        r_pending <= 1'b0;
      end else if (w_diff && r_diff_q) begin
        r_pending <= 1'b1;
      end
    end
  end

  // NOTE: the coefficient register is reset too, so every output reads 0 during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_d1 <= 1'b0;
      r_valid <= 1'b0;
      r_coef  <= '0;
    end else begin
      r_en_d1 <= rom_en;
      r_valid <= r_en_d1;
      if (r_en_d1) r_coef <= rom_data;
    end
  end

  fir_coef_sequencer_sample_timer #(
    .DIV (SAMPLE_DIV)
  ) u_sample_timer (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  assign rom_addr    = {r_bank_q, r_tap_idx};
  assign rom_en      = (r_state == LOAD);
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == FINISH);
  assign coef_out    = r_coef;
  assign coef_valid  = r_valid;
  assign sample_tick = w_tick;
  assign sample_en   = w_tick & ~busy;

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Directed bench for fir_coef_sequencer: a 32-tap/566-divider instance plus a
// 4-tap/3-divider instance, each fed by a synchronous ROM model.
module tb_fir_coef_sequencer;

  localparam int NT    = 32;
  localparam int CW    = 16;
  localparam int BW    = 3;
  localparam int DIV   = 566;
  localparam int TW    = 5;
  localparam int AW    = BW + TW;
  localparam int NT_S  = 4;
  localparam int DIV_S = 3;
  localparam int TW_S  = 2;
  localparam int AW_S  = BW + TW_S;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] bank_sel = '0;
  logic          load_req = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic [CW-1:0] rom_data = '0;
  logic [CW-1:0] coef_out;
  logic          coef_valid, sample_tick, sample_en, busy, done;

  logic            reset_s = 1'b0;
  logic [BW-1:0]   bank_sel_s = '0;
  logic            load_req_s = 1'b0;
  logic [AW_S-1:0] rom_addr_s;
  logic            rom_en_s;
  logic [CW-1:0]   rom_data_s = '0;
  logic [CW-1:0]   coef_out_s;
  logic            coef_valid_s, sample_tick_s, sample_en_s, busy_s, done_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_coef_sequencer #(.NUM_TAPS(NT), .COEF_W(CW), .BANK_W(BW), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .bank_sel(bank_sel), .load_req(load_req),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .coef_out(coef_out), .coef_valid(coef_valid), .sample_tick(sample_tick),
    .sample_en(sample_en), .busy(busy), .done(done)
  );

  fir_coef_sequencer #(.NUM_TAPS(NT_S), .COEF_W(CW), .BANK_W(BW), .SAMPLE_DIV(DIV_S)) dut_s (
    .clk(clk), .reset(reset_s), .bank_sel(bank_sel_s), .load_req(load_req_s),
    .rom_addr(rom_addr_s), .rom_en(rom_en_s), .rom_data(rom_data_s),
    .coef_out(coef_out_s), .coef_valid(coef_valid_s), .sample_tick(sample_tick_s),
    .sample_en(sample_en_s), .busy(busy_s), .done(done_s)
  );

  function automatic logic [CW-1:0] rom_word(input logic [7:0] a);
    return {~a, a ^ 8'h5A};
  endfunction

  // Expected {rom_en, busy, done, coef_valid} on load cycle c (cycle 0 = first LOAD cycle).
  function automatic logic [3:0] ctrl_model(input int c, input int nt);
    return {(c >= 0) && (c < nt), (c >= 0) && (c <= nt + 2), c == nt + 2, (c >= 2) && (c <= nt + 1)};
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_word(rom_addr);
  always @(posedge clk) if (rom_en_s) rom_data_s <= rom_word(8'(rom_addr_s));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_power_on();
    logic [3:0] exp_c, got_c;
    int strobes = 0;
    bank_sel = 3'd3;
    step();
    checks++;
    if ({rom_en, busy, done, coef_valid, sample_tick, sample_en} !== 6'b0 || rom_addr !== '0 || coef_out !== '0) begin
      failures++;
      $display("FAIL po_reset_state got ctrl=%b addr=%h coef=%h exp all zero",
               {rom_en, busy, done, coef_valid, sample_tick, sample_en}, rom_addr, coef_out);
    end
    reset = 1'b1;
    for (int c = 0; c <= NT + 3; c++) begin
      step();
      exp_c = ctrl_model(c, NT);
      got_c = {rom_en, busy, done, coef_valid};
      checks++;
      if (got_c !== exp_c) begin
        failures++;
        $display("FAIL po_ctrl cycle=%0d got=%b exp=%b", c, got_c, exp_c);
      end
      if (exp_c[3]) begin
        checks++;
        if (rom_addr !== {3'd3, TW'(NT - 1 - c)}) begin
          failures++;
          $display("FAIL po_addr cycle=%0d got=%h exp=%h", c, rom_addr, {3'd3, TW'(NT - 1 - c)});
        end
      end
      if (exp_c[0]) begin
        checks++;
        if (coef_out !== rom_word({3'd3, TW'(NT + 1 - c)})) begin
          failures++;
          $display("FAIL po_coef cycle=%0d got=%h exp=%h", c, coef_out, rom_word({3'd3, TW'(NT + 1 - c)}));
        end
      end
      if (coef_valid === 1'b1) strobes++;
    end
    checks++;
    if (strobes !== NT) begin
      failures++;
      $display("FAIL po_strobe_count got=%0d exp=%0d", strobes, NT);
    end
  endtask

  task automatic test_load_req();
    logic [3:0] exp_c, got_c;
    bank_sel = 3'd5;
    load_req = 1'b1;
    for (int c = 0; c <= NT + 3; c++) begin
      step();
      exp_c = ctrl_model(c, NT);
      got_c = {rom_en, busy, done, coef_valid};
      checks++;
      if (got_c !== exp_c) begin
        failures++;
        $display("FAIL lr_ctrl cycle=%0d got=%b exp=%b", c, got_c, exp_c);
      end
      if (exp_c[3]) begin
        checks++;
        if (rom_addr !== {3'd5, TW'(NT - 1 - c)}) begin
          failures++;
          $display("FAIL lr_addr cycle=%0d got=%h exp=%h", c, rom_addr, {3'd5, TW'(NT - 1 - c)});
        end
      end
      if (exp_c[0]) begin
        checks++;
        if (coef_out !== rom_word({3'd5, TW'(NT + 1 - c)})) begin
          failures++;
          $display("FAIL lr_coef cycle=%0d got=%h exp=%h", c, coef_out, rom_word({3'd5, TW'(NT + 1 - c)}));
        end
      end
      load_req = (c == 10);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({busy, rom_en} !== 2'b00) begin
        failures++;
        $display("FAIL lr_no_extra_load idle=%0d got busy/en=%b exp=00", i, {busy, rom_en});
      end
    end
  endtask

  task automatic test_bank_change();
    logic [3:0] exp_c, got_c;
    logic [BW-1:0] bk;
    int rel;
    load_req = 1'b1;
    for (int c = 0; c < 2 * (NT + 4); c++) begin
      step();
      rel = (c < NT + 4) ? c : c - (NT + 4);
      bk  = (c < NT + 4) ? 3'd5 : 3'd2;
      exp_c = ctrl_model(rel, NT);
      got_c = {rom_en, busy, done, coef_valid};
      checks++;
      if (got_c !== exp_c) begin
        failures++;
        $display("FAIL bc_ctrl cycle=%0d got=%b exp=%b", c, got_c, exp_c);
      end
      if (exp_c[3]) begin
        checks++;
        if (rom_addr !== {bk, TW'(NT - 1 - rel)}) begin
          failures++;
          $display("FAIL bc_addr cycle=%0d got=%h exp=%h", c, rom_addr, {bk, TW'(NT - 1 - rel)});
        end
      end
      if (exp_c[0]) begin
        checks++;
        if (coef_out !== rom_word({bk, TW'(NT + 1 - rel)})) begin
          failures++;
          $display("FAIL bc_coef cycle=%0d got=%h exp=%h", c, coef_out, rom_word({bk, TW'(NT + 1 - rel)}));
        end
      end
      load_req = 1'b0;
      if (c == 7) bank_sel = 3'd2;
    end
  endtask

  task automatic test_timer();
    int found = 0;
    for (int i = 0; i < DIV + 2 && found == 0; i++) begin
      step();
      if (sample_tick === 1'b1) found = 1;
    end
    checks++;
    if (found == 0 || sample_en !== 1'b1) begin
      failures++;
      $display("FAIL tm_first_tick got found=%0d en=%b exp found=1 en=1", found, sample_en);
    end
    for (int i = 1; i <= 2 * DIV; i++) begin
      step();
      checks++;
      if (sample_tick !== ((i % DIV) == 0)) begin
        failures++;
        $display("FAIL tm_period offset=%0d got=%b exp=%b", i, sample_tick, (i % DIV) == 0);
      end
      if (i == DIV) begin
        checks++;
        if ({busy, sample_en} !== 2'b10) begin
          failures++;
          $display("FAIL tm_tick_in_busy got busy/en=%b exp=10", {busy, sample_en});
        end
      end
      if (i == 2 * DIV) begin
        checks++;
        if ({busy, sample_en} !== 2'b01) begin
          failures++;
          $display("FAIL tm_tick_idle got busy/en=%b exp=01", {busy, sample_en});
        end
      end
      load_req = (i == DIV - 6);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [3:0] exp_c, got_c;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    for (int c = 1; c <= 15; c++) step();
    checks++;
    if ({busy, coef_valid} !== 2'b11) begin
      failures++;
      $display("FAIL rs_before got busy/valid=%b exp=11", {busy, coef_valid});
    end
    reset = 1'b0;
    bank_sel = 3'd6;
    #1;
    checks++;
    if ({rom_en, busy, done, coef_valid} !== 4'b0 || rom_addr !== '0 || coef_out !== '0) begin
      failures++;
      $display("FAIL rs_clear got ctrl=%b addr=%h coef=%h exp all zero",
               {rom_en, busy, done, coef_valid}, rom_addr, coef_out);
    end
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c <= NT + 3; c++) begin
      step();
      exp_c = ctrl_model(c, NT);
      got_c = {rom_en, busy, done, coef_valid};
      checks++;
      if (got_c !== exp_c) begin
        failures++;
        $display("FAIL rs_ctrl cycle=%0d got=%b exp=%b", c, got_c, exp_c);
      end
      if (exp_c[3]) begin
        checks++;
        if (rom_addr !== {3'd6, TW'(NT - 1 - c)}) begin
          failures++;
          $display("FAIL rs_addr cycle=%0d got=%h exp=%h", c, rom_addr, {3'd6, TW'(NT - 1 - c)});
        end
      end
    end
  endtask

  task automatic test_small_build();
    logic [3:0] exp_c, got_c;
    int strobes = 0;
    logic exp_tick;
    checks++;
    if ({rom_en_s, busy_s, done_s, coef_valid_s} !== 4'b0) begin
      failures++;
      $display("FAIL sm_reset_state got=%b exp=0000", {rom_en_s, busy_s, done_s, coef_valid_s});
    end
    bank_sel_s = 3'd1;
    reset_s = 1'b1;
    for (int c = 0; c <= NT_S + 3; c++) begin
      step();
      exp_c = ctrl_model(c, NT_S);
      got_c = {rom_en_s, busy_s, done_s, coef_valid_s};
      checks++;
      if (got_c !== exp_c) begin
        failures++;
        $display("FAIL sm_ctrl cycle=%0d got=%b exp=%b", c, got_c, exp_c);
      end
      if (exp_c[3]) begin
        checks++;
        if (rom_addr_s !== {3'd1, TW_S'(NT_S - 1 - c)}) begin
          failures++;
          $display("FAIL sm_addr cycle=%0d got=%h exp=%h", c, rom_addr_s, {3'd1, TW_S'(NT_S - 1 - c)});
        end
      end
      if (exp_c[0]) begin
        checks++;
        if (coef_out_s !== rom_word(8'({3'd1, TW_S'(NT_S + 1 - c)}))) begin
          failures++;
          $display("FAIL sm_coef cycle=%0d got=%h exp=%h", c, coef_out_s, rom_word(8'({3'd1, TW_S'(NT_S + 1 - c)})));
        end
      end
      if (coef_valid_s === 1'b1) strobes++;
      exp_tick = ((c % DIV_S) == 1);
      checks++;
      if ({sample_tick_s, sample_en_s} !== {exp_tick, exp_tick && (c > NT_S + 2)}) begin
        failures++;
        $display("FAIL sm_tick cycle=%0d got tick/en=%b exp=%b", c, {sample_tick_s, sample_en_s},
                 {exp_tick, exp_tick && (c > NT_S + 2)});
      end
    end
    checks++;
    if (strobes !== NT_S) begin
      failures++;
      $display("FAIL sm_strobe_count got=%0d exp=%0d", strobes, NT_S);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_power_on();
    test_load_req();
    test_bank_change();
    test_timer();
    test_reset_mid_load();
    test_small_build();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
